// File: rtl/weight_scan_controller_if.sv
// Bus bundle between the weight scan controller, the evaluator write stream,
// weightMemory and the move-selection FSM. The controller side is "slave",
// the environment driving requests and memory data is "master".
interface weight_scan_controller_if #(
    parameter int SCORE_W = 16
);
    logic               start;
    logic               wr_req;
    logic [3:0]         wr_weight;
    logic [4:0]         wr_x;
    logic [4:0]         wr_y;
    logic               occ_in;
    logic               mem_read;
    logic               mem_write;
    logic [3:0]         mem_weight;
    logic [4:0]         mem_x;
    logic [4:0]         mem_y;
    logic [4:0]         mem_xout;
    logic [4:0]         mem_yout;
    logic [26:0]        mem_data;
    logic               wr_grant;
    logic               busy;
    logic               done;
    logic               best_valid;
    logic [4:0]         best_x;
    logic [4:0]         best_y;
    logic [SCORE_W-1:0] best_score;

    modport slave (
        input  start, wr_req, wr_weight, wr_x, wr_y, occ_in, mem_data,
        output mem_read, mem_write, mem_weight, mem_x, mem_y, mem_xout, mem_yout,
        output wr_grant, busy, done, best_valid, best_x, best_y, best_score
    );

    modport master (
        output start, wr_req, wr_weight, wr_x, wr_y, occ_in, mem_data,
        input  mem_read, mem_write, mem_weight, mem_x, mem_y, mem_xout, mem_yout,
        input  wr_grant, busy, done, best_valid, best_x, best_y, best_score
    );
endinterface

// File: rtl/weight_scan_controller.sv
// Weight scan controller: arbitrates evaluator counter writes against
// full-board scans of weightMemory, scores every free cell in raster order
// and reports the highest-scoring one (earliest cell wins ties).
module weight_scan_controller #(
    parameter int         BRD_DIM = 19,
    parameter int         SCORE_W = 16,
    parameter logic [7:0] WGT0    = 8'd1,
    parameter logic [7:0] WGT1    = 8'd2,
    parameter logic [7:0] WGT2    = 8'd4,
    parameter logic [7:0] WGT3    = 8'd8,
    parameter logic [7:0] WGT4    = 8'd16,
    parameter logic [7:0] WGT5    = 8'd3,
    parameter logic [7:0] WGT6    = 8'd6,
    parameter logic [7:0] WGT7    = 8'd12,
    parameter logic [7:0] WGT8    = 8'd32
) (
    input  logic                     clk,
    input  logic                     reset,
    weight_scan_controller_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic               pend_q;
    logic [4:0]         x_q;
    logic [4:0]         y_q;
    logic               mem_read_q;
    logic               busy_q;
    logic               done_q;

    logic               vld_p1;
    logic               occ_p1;
    logic [4:0]         x_p1;
    logic [4:0]         y_p1;

    logic               best_valid_q;
    logic [4:0]         best_x_q;
    logic [4:0]         best_y_q;
    logic [SCORE_W-1:0] best_score_q;

    logic               wr_grant;
    logic               scan_go_d;
    logic               last_cell_d;
    logic [SCORE_W-1:0] score_d;
    logic               take_d;

    function automatic logic [7:0] wgt_of(input int k);
        case (k)
            0:       return WGT0;
            1:       return WGT1;
            2:       return WGT2;
            3:       return WGT3;
            4:       return WGT4;
            5:       return WGT5;
            6:       return WGT6;
            7:       return WGT7;
            default: return WGT8;
        endcase
    endfunction

    // Weighted sum of the nine 3-bit counters; cannot exceed 9*7*255.
    function automatic logic [SCORE_W-1:0] cell_score(input logic [26:0] d);
        logic [SCORE_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + SCORE_W'(d[3*k +: 3]) * SCORE_W'(wgt_of(k));
        end
        return acc;
    endfunction

    // Writes only reach the memory while idle; otherwise the requester holds wr_req.
    assign wr_grant       = bus.wr_req && (state_q == IDLE);
    assign bus.wr_grant   = wr_grant;
    assign bus.mem_write  = wr_grant;
    assign bus.mem_weight = bus.wr_weight;
    assign bus.mem_x      = bus.wr_x;
    assign bus.mem_y      = bus.wr_y;

    assign bus.mem_read   = mem_read_q;
    assign bus.mem_xout   = x_q;
    assign bus.mem_yout   = y_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.best_valid = best_valid_q;
    assign bus.best_x     = best_x_q;
    assign bus.best_y     = best_y_q;
    assign bus.best_score = best_score_q;

    // Scan launch decision, end-of-board detection and best-cell compare.
    always_comb begin
        scan_go_d   = (state_q == IDLE) && (bus.start || pend_q) && !bus.wr_req;
        last_cell_d = (x_q == 5'(BRD_DIM - 1)) && (y_q == 5'(BRD_DIM - 1));
        score_d     = cell_score(bus.mem_data);
        take_d      = vld_p1 && !occ_p1 && (!best_valid_q || (score_d > best_score_q));
    end

    // Sequencer: pending start, raster address counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (scan_go_d) begin
                        state_q    <= SCAN;
                        pend_q     <= 1'b0;
                        x_q        <= '0;
                        y_q        <= '0;
                        mem_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (bus.start) begin
                        pend_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_cell_d) begin
                        state_q    <= DRAIN;
                        mem_read_q <= 1'b0;
                        x_q        <= '0;
                        y_q        <= '0;
                    end else if (x_q == 5'(BRD_DIM - 1)) begin
                        x_q <= '0;
                        y_q <= y_q + 5'd1;
                    end else begin
                        x_q <= x_q + 5'd1;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Score stage: align occupancy/address with the registered memory data, track the best cell.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1       <= 1'b0;
            occ_p1       <= 1'b0;
            x_p1         <= '0;
            y_p1         <= '0;
            best_valid_q <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_score_q <= '0;
        end else begin
            vld_p1 <= (state_q == SCAN);
            occ_p1 <= bus.occ_in;
            x_p1   <= x_q;
            y_p1   <= y_q;
            if (scan_go_d) begin
                best_valid_q <= 1'b0;
                best_x_q     <= '0;
                best_y_q     <= '0;
                best_score_q <= '0;
            end else if (take_d) begin
                best_valid_q <= 1'b1;
                best_x_q     <= x_p1;
                best_y_q     <= y_p1;
                best_score_q <= score_d;
            end
        end
    end

endmodule
